// File: rtl/dm_resp_pkg.sv
// Shared constants, FSM encoding and store byte-enable legality for the
// data-memory responder.
package dm_resp_pkg;

    localparam int DM_WIDTH = 32;
    localparam int BE_W     = 4;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Stores may only cover a single byte, an aligned halfword or the full word.
    function automatic logic be_legal(input logic [BE_W-1:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_resp_if.sv
// Request/response channels between the CPU load/store path and the responder.
interface dm_resp_if;
    import dm_resp_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [BE_W-1:0]     req_be;
    logic [31:0]         req_addr;
    logic [DM_WIDTH-1:0] req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DM_WIDTH-1:0] rsp_rdata;
    logic                rsp_err;

    modport master (
        output req_valid, req_wr, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_resp_ram.sv
// Word array with per-byte write enables, synchronous write and
// combinational read.
module dm_resp_ram
    import dm_resp_pkg::*;
#(
    parameter int DM_DEPTH = 10
) (
    input  logic                clk,
    input  logic                we,
    input  logic [BE_W-1:0]     be,
    input  logic [DM_DEPTH-1:0] widx,
    input  logic [DM_WIDTH-1:0] wdata,
    output logic [DM_WIDTH-1:0] rdata
);

    logic [DM_WIDTH-1:0] mem_q [2**DM_DEPTH];

    // NOTE: the array has no reset; contents survive rst_n so committed stores persist.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[widx];

endmodule

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: accepts one load/store, waits LATENCY
// cycles, performs it, then holds the response until the consumer takes it.
module dm_resp
    import dm_resp_pkg::*;
#(
    parameter int DM_DEPTH = 10,
    parameter int LATENCY  = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_resp_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [31:0]         addr_q, addr_d;
    logic [DM_WIDTH-1:0] wdata_q, wdata_d;
    logic [DM_WIDTH-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                op_fire;
    logic                op_wr;
    logic [BE_W-1:0]     op_be;
    logic [31:0]         op_addr;
    logic [DM_WIDTH-1:0] op_wdata;
    logic                op_err;
    logic [DM_WIDTH-1:0] ram_rdata;

    // With zero latency the operation uses the live request, otherwise the latched one.
    always_comb begin
        op_wr    = wr_q;
        op_be    = be_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state_q == IDLE) begin
            op_wr    = bus.req_wr;
            op_be    = bus.req_be;
            op_addr  = bus.req_addr;
            op_wdata = bus.req_wdata;
        end
    end

    assign op_err = ((op_addr >> (DM_DEPTH + 2)) != 32'd0) || (op_wr && !be_legal(op_be));

    dm_resp_ram #(.DM_DEPTH(DM_DEPTH)) u_ram (
        .clk   (clk),
        .we    (op_fire && op_wr && !op_err),
        .be    (op_be),
        .widx  (op_addr[DM_DEPTH+1:2]),
        .wdata (op_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        op_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    be_d    = bus.req_be;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = LAT;
                    if (LATENCY == 0) begin
                        op_fire = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    op_fire = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (op_fire) begin
            err_d   = op_err;
            rdata_d = (op_err || op_wr) ? '0 : ram_rdata;
        end
    end

    // NOTE: all state updates here are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: three instances (LATENCY 2, 4, 0) share one
// driver; a vector table plus hand-written reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_dm_resp;

    localparam time PERIOD = 10;

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        drv_valid = 1'b0;
    logic        drv_wr = 1'b0;
    logic [3:0]  drv_be = '0;
    logic [31:0] drv_addr = '0;
    logic [31:0] drv_wdata = '0;
    logic        drv_rsp_ready = 1'b1;

    logic        mon_req_ready;
    logic        mon_rsp_valid;
    logic [31:0] mon_rsp_rdata;
    logic        mon_rsp_err;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    time  t_acc, t_prev;
    vec_t tv[20];

    always #(PERIOD/2) clk = ~clk;

    dm_resp_if bus_l2 ();
    dm_resp_if bus_l4 ();
    dm_resp_if bus_l0 ();

    assign bus_l2.req_valid = drv_valid && (sel == 2'd0);
    assign bus_l4.req_valid = drv_valid && (sel == 2'd1);
    assign bus_l0.req_valid = drv_valid && (sel == 2'd2);
    assign bus_l2.req_wr = drv_wr;      assign bus_l4.req_wr = drv_wr;      assign bus_l0.req_wr = drv_wr;
    assign bus_l2.req_be = drv_be;      assign bus_l4.req_be = drv_be;      assign bus_l0.req_be = drv_be;
    assign bus_l2.req_addr = drv_addr;  assign bus_l4.req_addr = drv_addr;  assign bus_l0.req_addr = drv_addr;
    assign bus_l2.req_wdata = drv_wdata; assign bus_l4.req_wdata = drv_wdata; assign bus_l0.req_wdata = drv_wdata;
    assign bus_l2.rsp_ready = drv_rsp_ready;
    assign bus_l4.rsp_ready = drv_rsp_ready;
    assign bus_l0.rsp_ready = drv_rsp_ready;

    dm_resp #(.DM_DEPTH(10), .LATENCY(2)) u_dut_l2 (.clk(clk), .rst_n(rst_n), .bus(bus_l2));
    dm_resp #(.DM_DEPTH(10), .LATENCY(4)) u_dut_l4 (.clk(clk), .rst_n(rst_n), .bus(bus_l4));
    dm_resp #(.DM_DEPTH(10), .LATENCY(0)) u_dut_l0 (.clk(clk), .rst_n(rst_n), .bus(bus_l0));

    always_comb begin
        mon_req_ready = bus_l2.req_ready;
        mon_rsp_valid = bus_l2.rsp_valid;
        mon_rsp_rdata = bus_l2.rsp_rdata;
        mon_rsp_err   = bus_l2.rsp_err;
        case (sel)
            2'd1: begin
                mon_req_ready = bus_l4.req_ready;
                mon_rsp_valid = bus_l4.rsp_valid;
                mon_rsp_rdata = bus_l4.rsp_rdata;
                mon_rsp_err   = bus_l4.rsp_err;
            end
            2'd2: begin
                mon_req_ready = bus_l0.req_ready;
                mon_rsp_valid = bus_l0.rsp_valid;
                mon_rsp_rdata = bus_l0.rsp_rdata;
                mon_rsp_err   = bus_l0.rsp_err;
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, " rsp_valid"}, 32'(mon_rsp_valid), 32'd0);
        check({name, " req_ready"}, 32'(mon_req_ready), 32'd1);
        check({name, " rsp_rdata"}, mon_rsp_rdata, 32'd0);
        check({name, " rsp_err"}, 32'(mon_rsp_err), 32'd0);
    endtask

    // Issue one request, check latency, response contents, hold stability and release.
    task automatic run_txn(input logic [1:0] s, input int lat, input logic wr, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int hold, input string name);
        exp_t e;
        int   n;
        @(negedge clk);
        sel = s;
        drv_wr = wr; drv_be = be; drv_addr = addr; drv_wdata = wdata;
        drv_valid = 1'b1;
        drv_rsp_ready = (hold == 0);
        n = 0;
        while (!mon_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " accept"}, 32'(mon_req_ready), 32'd1);
        @(posedge clk);
        t_acc = $time;
        e.rdata = exp_rdata;
        e.err = exp_err;
        sb.push_back(e);
        #1;
        drv_valid = 1'b0;
        drv_wr = 1'bx; drv_be = 'x; drv_addr = 'x; drv_wdata = 'x;
        n = 0;
        while (!mon_rsp_valid && n < 40) begin
            check({name, " busy"}, 32'(mon_req_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " latency"}, 32'(n + 1), 32'(lat + 1));
        e = sb.pop_front();
        check({name, " rdata"}, mon_rsp_rdata, e.rdata);
        check({name, " err"}, 32'(mon_rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, " hold valid"}, 32'(mon_rsp_valid), 32'd1);
            check({name, " hold rdata"}, mon_rsp_rdata, e.rdata);
            check({name, " hold err"}, 32'(mon_rsp_err), 32'(e.err));
            check({name, " hold req_ready"}, 32'(mon_req_ready), 32'd0);
        end
        drv_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_idle({name, " release"});
    endtask

    initial begin
        #(1000000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1'b1, 4'b1111, 32'h10,      32'hDEADBEEF, 32'h0,        1'b0, 0, "st_full"};
        tv[1]  = '{1'b0, 4'b0000, 32'h10,      32'h0,        32'hDEADBEEF, 1'b0, 0, "ld_full"};
        tv[2]  = '{1'b1, 4'b1111, 32'h20,      32'h11223344, 32'h0,        1'b0, 0, "st_init20"};
        tv[3]  = '{1'b1, 4'b0100, 32'h20,      32'hAAAAAAAA, 32'h0,        1'b0, 0, "st_b2"};
        tv[4]  = '{1'b1, 4'b0011, 32'h20,      32'h5555BBCC, 32'h0,        1'b0, 0, "st_h0"};
        tv[5]  = '{1'b0, 4'b1111, 32'h20,      32'h0,        32'h11AABBCC, 1'b0, 5, "ld_subword_bp"};
        tv[6]  = '{1'b1, 4'b1111, 32'h30,      32'h0BADCAFE, 32'h0,        1'b0, 0, "st_init30"};
        tv[7]  = '{1'b1, 4'b0101, 32'h30,      32'hFFFFFFFF, 32'h0,        1'b1, 0, "st_badbe"};
        tv[8]  = '{1'b0, 4'b1111, 32'h30,      32'h0,        32'h0BADCAFE, 1'b0, 0, "ld_after_badbe"};
        tv[9]  = '{1'b0, 4'b1111, 32'h10000,   32'h0,        32'h0,        1'b1, 0, "ld_oor"};
        tv[10] = '{1'b1, 4'b1111, 32'h0,       32'h01020304, 32'h0,        1'b0, 0, "st_init0"};
        tv[11] = '{1'b1, 4'b1111, 32'h10000,   32'hFFFFFFFF, 32'h0,        1'b1, 0, "st_oor"};
        tv[12] = '{1'b0, 4'b1111, 32'h0,       32'h0,        32'h01020304, 1'b0, 0, "ld_after_oor"};
        tv[13] = '{1'b1, 4'b1000, 32'h10,      32'h77777777, 32'h0,        1'b0, 0, "st_b3"};
        tv[14] = '{1'b1, 4'b0000, 32'h10,      32'h12345678, 32'h0,        1'b1, 0, "st_be0"};
        tv[15] = '{1'b1, 4'b1100, 32'h12,      32'h9999AAAA, 32'h0,        1'b0, 0, "st_h1"};
        tv[16] = '{1'b0, 4'b0101, 32'h13,      32'h0,        32'h9999BEEF, 1'b0, 0, "ld_be_ignored"};
        tv[17] = '{1'b1, 4'b0001, 32'h10,      32'h000000EE, 32'h0,        1'b0, 0, "st_b0"};
        tv[18] = '{1'b1, 4'b0010, 32'h10,      32'h0000DD00, 32'h0,        1'b0, 0, "st_b1"};
        tv[19] = '{1'b0, 4'b0000, 32'h10,      32'h0,        32'h9999DDEE, 1'b0, 0, "ld_bytes"};

        // Reset values on every instance.
        #3;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check_idle("reset");
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_txn(2'd0, 2, tv[i].wr, tv[i].be, tv[i].addr, tv[i].wdata,
                    tv[i].exp_rdata, tv[i].exp_err, tv[i].hold, tv[i].name);
        end

        // LATENCY=4: reset while a store waits drops it.
        run_txn(2'd1, 4, 1'b1, 4'b1111, 32'h40, 32'h12345678, 32'h0, 1'b0, 0, "l4_st_init");
        @(negedge clk);
        sel = 2'd1;
        drv_wr = 1'b1; drv_be = 4'b1111; drv_addr = 32'h40; drv_wdata = 32'hCAFEF00D;
        drv_valid = 1'b1;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        @(posedge clk);
        #1;
        check("l4 in wait req_ready", 32'(mon_req_ready), 32'd0);
        check("l4 in wait rsp_valid", 32'(mon_rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_idle("l4 async reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(2'd1, 4, 1'b0, 4'b1111, 32'h40, 32'h0, 32'h12345678, 1'b0, 0, "l4_ld_dropped");

        // LATENCY=4: reset while a committed store's response is pending keeps the write.
        @(negedge clk);
        drv_wr = 1'b1; drv_be = 4'b1111; drv_addr = 32'h44; drv_wdata = 32'hCAFEF00D;
        drv_valid = 1'b1;
        drv_rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        for (int n = 0; n < 40 && !mon_rsp_valid; n++) begin
            @(posedge clk);
            #1;
        end
        check("l4 resp pending", 32'(mon_rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("l4 reset in resp");
        @(negedge clk);
        rst_n = 1'b1;
        drv_rsp_ready = 1'b1;
        run_txn(2'd1, 4, 1'b0, 4'b0000, 32'h44, 32'h0, 32'hCAFEF00D, 1'b0, 0, "l4_ld_committed");

        // LATENCY=0: back-to-back requests every two cycles, including the top word.
        run_txn(2'd2, 0, 1'b1, 4'b1111, 32'h8, 32'hA5A5A5A5, 32'h0, 1'b0, 0, "l0_st8");
        t_prev = t_acc;
        run_txn(2'd2, 0, 1'b1, 4'b1111, 32'hFFC, 32'h600DF00D, 32'h0, 1'b0, 0, "l0_st_top");
        check("l0 spacing st", 32'(t_acc - t_prev), 32'(2 * PERIOD));
        t_prev = t_acc;
        for (int k = 0; k < 3; k++) begin
            run_txn(2'd2, 0, 1'b0, 4'b1111, (k == 1) ? 32'hFFC : 32'h8, 32'h0,
                    (k == 1) ? 32'h600DF00D : 32'hA5A5A5A5, 1'b0, 0, "l0_ld");
            check("l0 spacing ld", 32'(t_acc - t_prev), 32'(2 * PERIOD));
            t_prev = t_acc;
        end
        run_txn(2'd2, 0, 1'b0, 4'b1111, 32'h1000, 32'h0, 32'h0, 1'b1, 0, "l0_ld_oor");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
